// File: rtl/tx_frame_arbiter.sv
// Frame-granular round-robin arbiter for two AXI-Stream requesters feeding one registered TX stream.
// Optional per-port forwarded-frame counters are enabled with `define TX_ARB_STATS_EN.
module tx_frame_arbiter #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic [KEEP_W-1:0] s0_tkeep,
  input  logic              s0_tlast,
  input  logic              s0_tvalid,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic [KEEP_W-1:0] s1_tkeep,
  input  logic              s1_tlast,
  input  logic              s1_tvalid,
  output logic              s1_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
`ifdef TX_ARB_STATS_EN
  output logic [31:0]       frame_cnt0,
  output logic [31:0]       frame_cnt1,
`endif
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e            state_q, state_d;
  logic              last_served_q, last_served_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [KEEP_W-1:0] tkeep_q, tkeep_d;
  logic              tlast_q, tlast_d;
  logic              tvalid_q, tvalid_d;
  logic              out_free;
  logic              acc0, acc1;

  // Output slot can take a new beat when empty or being drained this cycle.
  assign out_free = !tvalid_q || m_tready;
  assign acc0     = s0_tvalid && s0_tready;
  assign acc1     = s1_tvalid && s1_tready;

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    s0_tready     = 1'b0;
    s1_tready     = 1'b0;
    grant         = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (s0_tvalid && s1_tvalid) begin
          state_d = last_served_q ? StGrant0 : StGrant1;
        end else if (s0_tvalid) begin
          state_d = StGrant0;
        end else if (s1_tvalid) begin
          state_d = StGrant1;
        end
      end
      StGrant0: begin
        grant     = 2'b01;
        s0_tready = out_free;
        if (s0_tvalid && out_free && s0_tlast) begin
          state_d       = StIdle;
          last_served_d = 1'b0;
        end
      end
      StGrant1: begin
        grant     = 2'b10;
        s1_tready = out_free;
        if (s1_tvalid && out_free && s1_tlast) begin
          state_d       = StIdle;
          last_served_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (acc0) begin
      tdata_d  = s0_tdata;
      tkeep_d  = s0_tkeep;
      tlast_d  = s0_tlast;
      tvalid_d = 1'b1;
    end else if (acc1) begin
      tdata_d  = s1_tdata;
      tkeep_d  = s1_tkeep;
      tlast_d  = s1_tlast;
      tvalid_d = 1'b1;
    end else if (m_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      last_served_q <= 1'b1;
      tdata_q       <= '0;
      tkeep_q       <= '0;
      tlast_q       <= 1'b0;
      tvalid_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      tdata_q       <= tdata_d;
      tkeep_q       <= tkeep_d;
      tlast_q       <= tlast_d;
      tvalid_q      <= tvalid_d;
    end
  end

  assign m_tdata  = tdata_q;
  assign m_tkeep  = tkeep_q;
  assign m_tlast  = tlast_q;
  assign m_tvalid = tvalid_q;

`ifdef TX_ARB_STATS_EN
  logic [31:0] cnt0_q, cnt0_d;
  logic [31:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (acc0 && s0_tlast) cnt0_d = cnt0_q + 32'd1;
    if (acc1 && s1_tlast) cnt1_d = cnt1_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign frame_cnt0 = cnt0_q;
  assign frame_cnt1 = cnt1_q;
`endif

endmodule
